flap_gravity_ctrl: RTL
======================

Name: flap_gravity_ctrl

Overview:
- Upstream input stage for the bird movement block: turns the raw player push-button into one-cycle flap pulses (L) and generates periodic gravity pulses (R).
- Owns the game-run state machine: idle until first flap, running, dead on lose.
- Gravity period is programmable at runtime via a speed-up pulse, so difficulty ramps as score rises.
- Outputs drive the bird block's L/R inputs directly.

Parameters:
- CNT_W, 8, width of the gravity counter and period register.
- GRAV_PERIOD, 24, gravity interval in clk cycles after reset (must be ≥ 2 and < 2^CNT_W).
- GRAV_STEP, 2, amount subtracted from the period on each speed_up pulse.
- GRAV_MIN, 6, floor of the gravity period (≥ 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- key_n  input  1  raw, asynchronous push-button, active-low (0 = pressed).
- lose  input  1  collision/lose indicator from the game logic, synchronous to clk.
- speed_up  input  1  one-cycle pulse; shortens the gravity period.
- L  output  1  one-cycle flap pulse to the bird block.
- R  output  1  one-cycle gravity pulse to the bird block.
- running  output  1  high while in the RUN state.
- period  output  CNT_W  current gravity period (debug/score display).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, L=0, R=0, running=0, counter=0, period=GRAV_PERIOD, synchronizer flops=0 (released button). All outputs hold these values while reset=0.
- Input conditioning: press = ~key_n passes through a 2-flop synchronizer (s1, s2) plus a history flop p. edge = s2 & ~p.
- Only a rising edge of press produces a flap. Holding the button produces exactly one flap. Auto-repeat is not allowed.
- Latency: key_n falls before edge k. s1=1 after edge k, s2=1 after edge k+1, L=1 during the cycle after edge k+2 for exactly one cycle.
- States:
  - IDLE: L=0, R=0, counter held at 0. A detected edge moves to RUN and emits that flap (L=1) on the same transition. lose is ignored in IDLE.
  - RUN: running=1. On edge, L=1 for one cycle and counter←0. Otherwise counter increments each cycle. When counter = period−1: R=1 for one cycle and counter←0.
  - DEAD: L=0, R=0, running=0, counter frozen. Exited only by reset.
- Transition into DEAD: in RUN, lose=1 sampled at an edge moves to DEAD at that edge. L and R are 0 from that edge on. lose has priority over a flap or gravity event in the same cycle.
- Mutual exclusion: L and R are never 1 in the same cycle. A flap in the same cycle as a gravity terminal count wins: L=1, R=0, counter←0.
- speed_up:
  - Accepted in any state. At the next edge, period ← max(period − GRAV_STEP, GRAV_MIN). Arithmetic is unsigned; no underflow wrap.
  - At period=GRAV_MIN, further pulses leave period unchanged.
  - If the new period ≤ counter+1, the terminal condition is counter ≥ period−1, so R fires on the next cycle rather than waiting for wrap-around.
- A speed_up held high for N cycles applies N decrements.
- Reset asserted mid-game (any state, mid-pulse) returns immediately to the reset values. A pulse in progress is truncated.

Test Plan:
- Reset, key_n=1 for 50 cycles -> L=0, R=0, running=0, period=24 throughout (IDLE, no gravity).
- key_n=0 at cycle 10, held 20 cycles -> exactly one L pulse, 3 edges after the fall; running=1 afterwards. Then with no press -> R pulses every 24 cycles, first one 24 cycles after the L pulse.
- In RUN, press timed so the edge coincides with counter=23 -> L=1, R=0 that cycle; next R comes 24 cycles later.
- 10 speed_up pulses from period=24 -> period goes 22, 20, …, 6, then stays at 6. With counter=15 and a pulse taking period 18→16, R fires on the next cycle.
- lose=1 in the same cycle as a pending flap -> DEAD; L=0, R=0, running=0 forever, and further presses are ignored. Then reset=0 for 1 cycle -> IDLE with period=24.
- reset driven low asynchronously between clock edges while R=1 -> R, L, and running drop immediately without waiting for clk.

Source files
------------

// File: rtl/flap_gravity_ctrl.sv
// Input stage for the bird block: debounced-by-edge flap pulses (L), periodic gravity pulses (R)
// and the IDLE/RUN/DEAD game-run state machine with a runtime-shortenable gravity period.
module flap_gravity_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned GRAV_PERIOD = 24,
    parameter int unsigned GRAV_STEP   = 2,
    parameter int unsigned GRAV_MIN    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_n,
    input  logic             lose,
    input  logic             speed_up,
    output logic             L,
    output logic             R,
    output logic             running,
    output logic [CNT_W-1:0] period
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam logic [CNT_W-1:0] P_RST   = CNT_W'(GRAV_PERIOD);
    localparam logic [CNT_W-1:0] P_STEP  = CNT_W'(GRAV_STEP);
    localparam logic [CNT_W-1:0] P_FLOOR = CNT_W'(GRAV_MIN);
    localparam logic [CNT_W:0]   P_THR   = (CNT_W + 1)'(GRAV_MIN + GRAV_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   EXT_ONE = (CNT_W + 1)'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_s1;
    logic             r_s2;
    logic             r_p;
    logic             r_l;
    logic             r_r;

    logic [1:0]       w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_period_d;
    logic [CNT_W-1:0] w_period_dec;
    logic             w_l_d;
    logic             w_r_d;
    logic             w_edge;
    logic             w_term;

    assign w_edge = r_s2 & ~r_p;

    // >= rather than == so a period shortened below the running count fires on the next cycle
    assign w_term = ({1'b0, r_cnt} + EXT_ONE) >= {1'b0, r_period};

    // Compare in CNT_W+1 bits so the floor check cannot wrap
    assign w_period_dec = ({1'b0, r_period} >= P_THR) ? (r_period - P_STEP) : P_FLOOR;
    assign w_period_d   = speed_up ? w_period_dec : r_period;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_l_d     = 1'b0;
        w_r_d     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_d = '0;
                if (w_edge) begin
                    w_state_d = ST_RUN;
                    w_l_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (lose) begin
                    w_state_d = ST_DEAD;
                end else if (w_edge) begin
                    w_l_d   = 1'b1;
                    w_cnt_d = '0;
                end else if (w_term) begin
                    w_r_d   = 1'b1;
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            ST_DEAD: begin
                w_state_d = ST_DEAD;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_p      <= 1'b0;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= P_RST;
            r_l      <= 1'b0;
            r_r      <= 1'b0;
        end else begin
            r_s1     <= ~key_n;
            r_s2     <= r_s1;
            r_p      <= r_s2;
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_period <= w_period_d;
            r_l      <= w_l_d;
            r_r      <= w_r_d;
        end
    end

    assign L       = r_l;
    assign R       = r_r;
    assign running = (r_state == ST_RUN);
    assign period  = r_period;

endmodule
